// File: rtl/dcsg_seq_pkg.sv
// Shared definitions for the DCSG command sequencer: opcodes, DCSG byte-format
// field positions, FSM state type and the command-to-byte expansion.
package dcsg_seq_pkg;

  localparam logic [1:0] OP_RAW  = 2'b00;
  localparam logic [1:0] OP_TONE = 2'b01;
  localparam logic [1:0] OP_ATT  = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  localparam int DCSG_CLK = 3579545;

  // DCSG latch byte: {latch, ch[1:0], type, payload[3:0]}
  localparam int BIT_LATCH = 7;
  localparam int CH_HI     = 6;
  localparam int CH_LO     = 5;
  localparam int BIT_TYPE  = 4;
  localparam logic [1:0] NOISE_CH = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT1,
    S_GAP,
    S_EMIT2,
    S_HOLD,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        two;
    logic        is_wait;
    logic [13:0] n;
  } expand_t;

  function automatic expand_t expand_cmd(input logic [15:0] cmd);
    expand_t    e;
    logic [1:0] ch;
    e    = '0;
    ch   = cmd[13:12];
    e.n  = cmd[13:0];
    case (cmd[15:14])
      OP_RAW: begin
        e.b0 = cmd[7:0];
      end
      OP_TONE: begin
        e.b0[BIT_LATCH]   = 1'b1;
        e.b0[CH_HI:CH_LO] = ch;
        if (ch == NOISE_CH) begin
          e.b0[2:0] = cmd[2:0];
        end else begin
          e.b0[3:0] = cmd[3:0];
          e.b1[5:0] = cmd[9:4];
          e.two     = 1'b1;
        end
      end
      OP_ATT: begin
        e.b0[BIT_LATCH]   = 1'b1;
        e.b0[CH_HI:CH_LO] = ch;
        e.b0[BIT_TYPE]    = 1'b1;
        e.b0[3:0]         = cmd[3:0];
      end
      default: begin
        e.is_wait = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dcsg_seq_if.sv
// CPU-side command port and DCSG-side write port of the sequencer.
interface dcsg_seq_if #(
  parameter int DEPTH_L2 = 4
) ();
  logic              cmd_valid;
  logic [15:0]       cmd_data;
  logic              cmd_ready;
  logic              flush;
  logic              pause;
  logic              busy;
  logic [DEPTH_L2:0] level;
  logic              wr;
  logic [7:0]        data;

  modport master (
    output cmd_valid, cmd_data, flush, pause,
    input  cmd_ready, busy, level, wr, data
  );

  modport slave (
    input  cmd_valid, cmd_data, flush, pause,
    output cmd_ready, busy, level, wr, data
  );
endinterface

// File: rtl/dcsg_seq_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full flag and synchronous flush.
module sync_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH_L2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  input  logic              flush,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic [DEPTH_L2:0] level
);

  localparam int DEPTH = 1 << DEPTH_L2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_L2-1:0] wr_ptr;
  logic [DEPTH_L2-1:0] rd_ptr;
  logic [DEPTH_L2:0]   count;
  logic [DEPTH_L2:0]   count_nxt;
  logic                full_q;
  logic                push_ok;
  logic                pop_ok;

  // full_q is checked rather than count, so a pop in the same cycle never frees a slot early
  assign push_ok = push & ~full_q & ~flush;
  assign pop_ok  = pop & (count != '0) & ~flush;

  always_comb begin
    count_nxt = count + (DEPTH_L2+1)'(push_ok) - (DEPTH_L2+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == (DEPTH_L2+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = full_q;
  assign level = count;

endmodule

// File: rtl/dcsg_seq.sv
// DCSG command sequencer: pops queued commands, expands them into DCSG register
// bytes with enforced write spacing, and executes prescaled timed waits.
module dcsg_seq
  import dcsg_seq_pkg::*;
#(
  parameter int CLK      = DCSG_CLK,
  parameter int TICK_HZ  = 44100,
  parameter int DEPTH_L2 = 4,
  parameter int WR_GAP   = 2
) (
  input logic       clk,
  input logic       rst_n,
  dcsg_seq_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for a command; pops when queue non-empty, not paused, not flushing
  // EMIT1  | wr strobe with byte0
  // GAP    | spacing between the two bytes of a tone command
  // EMIT2  | wr strobe with byte1 (tone period high bits)
  // HOLD   | spacing after the last byte before the next command may emit
  // WAIT   | counting down prescaled ticks

  localparam int DIV        = (CLK + TICK_HZ / 2) / TICK_HZ;
  localparam int PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W      = $clog2(WR_GAP);
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WR_GAP - 2);

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  expand_t           cmd_x;

  logic              emit0;
  logic              emit1;
  logic              gap_load;
  logic              wait_load;
  logic              wait_dec;
  logic              wait_clr;

  logic              wr_q;
  logic [7:0]        data_q;
  logic [7:0]        b1_q;
  logic              two_q;
  logic [GAP_W-1:0]  gap_q;
  logic [13:0]       wait_q;
  logic [PRE_W-1:0]  pre_q;
  logic              tick;

  sync_fifo #(
    .WIDTH    (16),
    .DEPTH_L2 (DEPTH_L2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .din   (bus.cmd_data),
    .pop   (pop),
    .flush (bus.flush),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (bus.level)
  );

  assign cmd_x = expand_cmd(fifo_dout);
  assign tick  = (pre_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    emit0     = 1'b0;
    emit1     = 1'b0;
    gap_load  = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    wait_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !bus.pause && !bus.flush) begin
          pop = 1'b1;
          if (cmd_x.is_wait) begin
            if (cmd_x.n != '0) begin
              state_d   = S_WAIT;
              wait_load = 1'b1;
            end
          end else begin
            state_d = S_EMIT1;
            emit0   = 1'b1;
          end
        end
      end
      S_EMIT1: begin
        gap_load = 1'b1;
        state_d  = two_q ? S_GAP : S_HOLD;
      end
      // flush is deliberately ignored here so a latched tone never loses its data byte
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_EMIT2;
          emit1   = 1'b1;
        end
      end
      S_EMIT2: begin
        gap_load = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (gap_q == '0) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (bus.flush) begin
          state_d  = S_IDLE;
          wait_clr = 1'b1;
        end else if (tick) begin
          wait_dec = 1'b1;
          if (wait_q == 14'd1) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      data_q <= '0;
      b1_q   <= '0;
      two_q  <= 1'b0;
      gap_q  <= '0;
      wait_q <= '0;
      pre_q  <= '0;
    end else begin
      wr_q <= emit0 | emit1;
      if (emit0)      data_q <= cmd_x.b0;
      else if (emit1) data_q <= b1_q;
      if (emit0) begin
        b1_q  <= cmd_x.b1;
        two_q <= cmd_x.two;
      end
      if (gap_load)          gap_q <= GAP_RELOAD;
      else if (gap_q != '0)  gap_q <= gap_q - 1'b1;
      if (wait_clr)          wait_q <= '0;
      else if (wait_load)    wait_q <= cmd_x.n;
      else if (wait_dec)     wait_q <= wait_q - 1'b1;
      pre_q <= tick ? PRE_RELOAD : pre_q - 1'b1;
    end
  end

  assign bus.cmd_ready = ~fifo_full;
  assign bus.busy      = ~fifo_empty | (state_q != S_IDLE);
  assign bus.wr        = wr_q;
  assign bus.data      = data_q;

endmodule

// File: tb/tb_dcsg_seq.sv
// Self-checking bench for dcsg_seq: scoreboard on the wr/data stream against a
// byte-level command model plus a minimal DCSG register decoder.
module tb_dcsg_seq;

  localparam int TICK_HZ  = 44100;
  localparam int CLK_HZ   = TICK_HZ * 10;
  localparam int DIV      = 10;
  localparam int DEPTH_L2 = 4;
  localparam int DEPTH    = 16;
  localparam int WR_GAP   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dcsg_seq_if #(.DEPTH_L2(DEPTH_L2)) bus ();

  dcsg_seq #(
    .CLK      (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .DEPTH_L2 (DEPTH_L2),
    .WR_GAP   (WR_GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_d[$];
  int         got_c[$];
  logic [7:0] exp_d[$];
  bit         exp_tight[$];

  logic [9:0] per_m [4];
  logic [1:0] lat_ch   = 2'd0;
  logic       lat_type = 1'b0;

  always @(negedge clk) begin
    if (bus.wr === 1'b1) begin
      got_d.push_back(bus.data);
      got_c.push_back(cyc);
      if (bus.data[7]) begin
        lat_ch   = bus.data[6:5];
        lat_type = bus.data[4];
        if (!bus.data[4]) per_m[lat_ch][3:0] = bus.data[3:0];
      end else if (!lat_type) begin
        per_m[lat_ch][9:4] = bus.data[5:0];
      end
    end
  end

  task automatic clear_queues();
    got_d.delete(); got_c.delete(); exp_d.delete(); exp_tight.delete();
  endtask

  // expected DCSG bytes from a command word, by field arithmetic
  task automatic model_cmd(input logic [15:0] w);
    int op, ch, per;
    op  = int'(w[15:14]);
    ch  = int'(w[13:12]);
    per = int'(w[9:0]);
    case (op)
      0: begin exp_d.push_back(w[7:0]); exp_tight.push_back(1'b0); end
      1: begin
        if (ch == 3) begin
          exp_d.push_back(8'(224 + per % 8)); exp_tight.push_back(1'b0);
        end else begin
          exp_d.push_back(8'(128 + ch * 32 + per % 16)); exp_tight.push_back(1'b0);
          exp_d.push_back(8'(per / 16));                exp_tight.push_back(1'b1);
        end
      end
      2: begin exp_d.push_back(8'(144 + ch * 32 + int'(w[3:0]))); exp_tight.push_back(1'b0); end
      default: ;
    endcase
  endtask

  task automatic push_word(input logic [15:0] w, output bit ok);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    ok = bus.cmd_ready;
    @(posedge clk);
    #1;
    last_acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (got_d.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.flush = 1'b0; bus.pause = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.wr !== 1'b0)        begin n_bad++; $display("FAIL reset_wr got=%b want=0", bus.wr); end
    n_cmp++; if (bus.data !== 8'h00)     begin n_bad++; $display("FAIL reset_data got=%h want=00", bus.data); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_cmp++; if (bus.level !== 5'd0)     begin n_bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
  endtask

  task automatic test_tone();
    bit ok, okw;
    clear_queues();
    push_word(16'h52A5, ok);
    wait_bytes(2, 50, okw);
    n_cmp++; if (!okw) begin n_bad++; $display("FAIL tone_timeout got=%0d bytes want=2", got_d.size()); end
    if (okw) begin
      n_cmp++; if (got_d[0] !== 8'hA5) begin n_bad++; $display("FAIL tone_b0 got=%h want=a5", got_d[0]); end
      n_cmp++; if (got_d[1] !== 8'h2A) begin n_bad++; $display("FAIL tone_b1 got=%h want=2a", got_d[1]); end
      n_cmp++; if (got_c[1] - got_c[0] != WR_GAP) begin n_bad++; $display("FAIL tone_gap got=%0d want=%0d", got_c[1] - got_c[0], WR_GAP); end
      n_cmp++; if (per_m[1] !== 10'h2A5) begin n_bad++; $display("FAIL tone_period got=%h want=2a5", per_m[1]); end
    end
    drain(ok);
  endtask

  task automatic test_back_to_back();
    bit ok, okw;
    clear_queues();
    push_word(16'hB007, ok);
    push_word(16'h00E4, ok);
    wait_bytes(2, 50, okw);
    n_cmp++; if (!okw) begin n_bad++; $display("FAIL b2b_timeout got=%0d bytes want=2", got_d.size()); end
    if (okw) begin
      n_cmp++; if (got_d[0] !== 8'hF7) begin n_bad++; $display("FAIL b2b_att got=%h want=f7", got_d[0]); end
      n_cmp++; if (got_d[1] !== 8'hE4) begin n_bad++; $display("FAIL b2b_raw got=%h want=e4", got_d[1]); end
      n_cmp++; if (got_c[1] - got_c[0] < WR_GAP) begin n_bad++; $display("FAIL b2b_gap got=%0d want>=%0d", got_c[1] - got_c[0], WR_GAP); end
    end
    drain(ok);
  endtask

  task automatic test_wait();
    bit ok, okw;
    int acc_w, off, lo, hi;
    clear_queues();
    push_word(16'hC003, ok);
    acc_w = last_acc;
    push_word(16'h009F, ok);
    wait_bytes(1, 200, okw);
    // wait of 3 ticks lasts 2*DIV+1..3*DIV clocks, plus the pop and emit cycles of the RAW
    lo = 2 * DIV + 1;
    hi = 3 * DIV + 2;
    n_cmp++; if (!okw) begin n_bad++; $display("FAIL wait_timeout got=%0d bytes want=1", got_d.size()); end
    if (okw) begin
      off = got_c[0] - acc_w;
      n_cmp++; if (got_d[0] !== 8'h9F) begin n_bad++; $display("FAIL wait_byte got=%h want=9f", got_d[0]); end
      n_cmp++; if (off < lo || off > hi) begin n_bad++; $display("FAIL wait_delay got=%0d want=%0d..%0d", off, lo, hi); end
    end
    drain(ok);
  endtask

  task automatic test_full_pause();
    bit ok, okw;
    logic [15:0] w;
    clear_queues();
    @(negedge clk);
    bus.pause = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = {8'h00, 8'($urandom)};
      push_word(w, ok);
      if (ok) model_cmd(w);
      if (i == DEPTH - 1) begin
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b want=0", bus.cmd_ready); end
      end
      if (i == DEPTH) begin
        n_cmp++; if (ok) begin n_bad++; $display("FAIL full_drop got=accepted want=dropped"); end
      end
    end
    @(negedge clk);
    n_cmp++; if (bus.level !== 5'd16) begin n_bad++; $display("FAIL full_level got=%0d want=16", bus.level); end
    n_cmp++; if (got_d.size() != 0) begin n_bad++; $display("FAIL pause_hold got=%0d bytes want=0", got_d.size()); end
    bus.pause = 1'b0;
    wait_bytes(DEPTH, 400, okw);
    repeat (10) @(negedge clk);
    n_cmp++; if (got_d.size() != DEPTH || exp_d.size() != DEPTH) begin n_bad++; $display("FAIL full_count got=%0d want=%0d", got_d.size(), DEPTH); end
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      n_cmp++; if (got_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL full_order[%0d] got=%h want=%h", k, got_d[k], exp_d[k]); end
    end
    drain(ok);
  endtask

  task automatic test_flush_gap();
    bit ok, okw;
    logic [9:0] per;
    logic [1:0] ch;
    clear_queues();
    per = 10'($urandom);
    ch  = 2'($urandom_range(0, 2));
    @(negedge clk);
    bus.pause = 1'b1;
    push_word({2'b01, ch, 2'b00, per}, ok);
    for (int i = 0; i < 3; i++) push_word(16'h0011 + 16'(i), ok);
    @(negedge clk);
    bus.pause = 1'b0;
    wait_bytes(1, 20, okw);
    @(posedge clk);
    #1;
    bus.flush     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 16'h0055;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (got_d.size() != 2) begin n_bad++; $display("FAIL flush_count got=%0d want=2", got_d.size()); end
    if (got_d.size() >= 2) begin
      n_cmp++; if (got_d[1] !== 8'(int'(per) / 16)) begin n_bad++; $display("FAIL flush_b1 got=%h want=%h", got_d[1], 8'(int'(per) / 16)); end
      n_cmp++; if (got_c[1] - got_c[0] != WR_GAP) begin n_bad++; $display("FAIL flush_gap got=%0d want=%0d", got_c[1] - got_c[0], WR_GAP); end
    end
    n_cmp++; if (bus.level !== 5'd0) begin n_bad++; $display("FAIL flush_level got=%0d want=0", bus.level); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_in_wait();
    bit ok, okw;
    clear_queues();
    push_word(16'h00A3, ok);
    push_word(16'hC064, ok);
    push_word(16'h0001, ok);
    push_word(16'h0002, ok);
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.level !== 5'd2) begin n_bad++; $display("FAIL rstw_level_pre got=%0d want=2", bus.level); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.wr !== 1'b0)    begin n_bad++; $display("FAIL rstw_wr got=%b want=0", bus.wr); end
    n_cmp++; if (bus.data !== 8'h00) begin n_bad++; $display("FAIL rstw_data got=%h want=00", bus.data); end
    n_cmp++; if (bus.level !== 5'd0) begin n_bad++; $display("FAIL rstw_level got=%0d want=0", bus.level); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL rstw_busy got=%b want=0", bus.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    push_word(16'h0080, ok);
    wait_bytes(1, 20, okw);
    repeat (10) @(negedge clk);
    n_cmp++; if (got_d.size() != 1) begin n_bad++; $display("FAIL rstw_count got=%0d want=1", got_d.size()); end
    if (got_d.size() >= 1) begin
      n_cmp++; if (got_d[0] !== 8'h80) begin n_bad++; $display("FAIL rstw_byte got=%h want=80", got_d[0]); end
      n_cmp++; if (got_c[0] - last_acc != 1) begin n_bad++; $display("FAIL rstw_latency got=%0d want=1", got_c[0] - last_acc); end
    end
  endtask

  task automatic test_random();
    bit ok, okw;
    logic [15:0] w;
    logic [1:0]  op;
    clear_queues();
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = {op, 14'($urandom)};
      if (op == 2'b11) w = 16'hC000 | 16'($urandom_range(0, 2));
      push_word(w, ok);
      if (ok) model_cmd(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_bytes(exp_d.size(), 3000, okw);
    repeat (20) @(negedge clk);
    n_cmp++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rand_count got=%0d want=%0d", got_d.size(), exp_d.size()); end
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      n_cmp++; if (got_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL rand_byte[%0d] got=%h want=%h", k, got_d[k], exp_d[k]); end
      if (k > 0) begin
        n_cmp++;
        if (exp_tight[k] ? (got_c[k] - got_c[k-1] != WR_GAP) : (got_c[k] - got_c[k-1] < WR_GAP)) begin
          n_bad++; $display("FAIL rand_spacing[%0d] got=%0d want=%s%0d", k, got_c[k] - got_c[k-1], exp_tight[k] ? "" : ">=", WR_GAP);
        end
      end
    end
    drain(ok);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tone();
    test_back_to_back();
    test_wait();
    test_full_pause();
    test_flush_gap();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
